// File: rtl/wb_stage_forward.sv
// wb_stage_forward: MEM/WB pipeline register, register-file write port, EX forwarding selects and commit counter
//    in : clk, reset (sync, active-low), stall, flush, mem_regwrite, mem_memtoreg, mem_rd, mem_aluresult, mem_readdata, ex_rs, ex_rt
//    out: regwrite, writereg, writedata, forwarda, forwardb (00 regfile, 10 MEM, 01 WB), wbcount
module wb_stage_forward #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall,
   input  logic          flush,
   input  logic          mem_regwrite,
   input  logic          mem_memtoreg,
   input  logic [AW-1:0] mem_rd,
   input  logic [DW-1:0] mem_aluresult,
   input  logic [DW-1:0] mem_readdata,
   input  logic [AW-1:0] ex_rs,
   input  logic [AW-1:0] ex_rt,
   output logic          regwrite,
   output logic [AW-1:0] writereg,
   output logic [DW-1:0] writedata,
   output logic [1:0]    forwarda,
   output logic [1:0]    forwardb,
   output logic [31:0]   wbcount
);
   logic          wb_regwrite_q;
   logic [AW-1:0] wb_rd_q;
   logic [DW-1:0] wb_data_q;
   logic          mem_fwd_ok;
   always_ff @(posedge clk) begin
      if (!reset) begin
         wb_regwrite_q <= 1'b0;
         wb_rd_q       <= '0;
         wb_data_q     <= '0;
         wbcount       <= '0;
      end else begin
         // count only on the edge the instruction leaves WB, so a stalled one counts once
         if (regwrite && !stall && !flush) wbcount <= wbcount + 32'd1;
         if (flush) begin
            wb_regwrite_q <= 1'b0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
         end else if (!stall) begin
            wb_regwrite_q <= mem_regwrite;
            wb_rd_q       <= mem_rd;
            wb_data_q     <= mem_memtoreg ? mem_readdata : mem_aluresult;
         end
      end
   end
   assign regwrite  = wb_regwrite_q && (wb_rd_q != '0);
   assign writereg  = wb_rd_q;
   assign writedata = wb_data_q;
   assign mem_fwd_ok = mem_regwrite && (mem_rd != '0);
   // regwrite already excludes $0, so ex_rs/ex_rt of 0 always falls through to 00
   always_comb begin
      forwarda = (mem_fwd_ok && mem_rd == ex_rs) ? 2'b10 : (regwrite && wb_rd_q == ex_rs) ? 2'b01 : 2'b00;
      forwardb = (mem_fwd_ok && mem_rd == ex_rt) ? 2'b10 : (regwrite && wb_rd_q == ex_rt) ? 2'b01 : 2'b00;
   end
endmodule

// File: tb/tb_wb_stage_forward.sv
// tb_wb_stage_forward: directed self-checking bench for wb_stage_forward
module tb_wb_stage_forward;
   logic        clk = 1'b0;
   logic        reset, stall, flush, mem_regwrite, mem_memtoreg;
   logic [4:0]  mem_rd, ex_rs, ex_rt;
   logic [31:0] mem_aluresult, mem_readdata;
   logic        regwrite;
   logic [4:0]  writereg;
   logic [31:0] writedata;
   logic [1:0]  forwarda, forwardb;
   logic [31:0] wbcount;
   logic [31:0] rf [32];
   int          tests = 0;
   int          fails = 0;
   wb_stage_forward dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg), .mem_rd(mem_rd),
      .mem_aluresult(mem_aluresult), .mem_readdata(mem_readdata),
      .ex_rs(ex_rs), .ex_rt(ex_rt),
      .regwrite(regwrite), .writereg(writereg), .writedata(writedata),
      .forwarda(forwarda), .forwardb(forwardb), .wbcount(wbcount)
   );
   always #5 clk = ~clk;
   always @(negedge clk) if (regwrite) rf[writereg] <= writedata;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   initial begin
      for (int i = 0; i < 32; i++) rf[i] = '0;
      reset = 0; stall = 0; flush = 0; mem_regwrite = 1; mem_memtoreg = 0;
      mem_rd = 5; mem_aluresult = 32'hAAAA; mem_readdata = 0; ex_rs = 0; ex_rt = 0;
      tick; tick;
      reset = 1; mem_regwrite = 0;
      chk("rst_regwrite", regwrite, 0);
      chk("rst_writereg", writereg, 0);
      chk("rst_writedata", writedata, 0);
      chk("rst_wbcount", wbcount, 0);
      chk("rst_fwda", forwarda, 0);
      mem_regwrite = 1; mem_memtoreg = 0; mem_rd = 7; mem_aluresult = 32'h1234;
      tick;
      chk("alu_regwrite", regwrite, 1);
      chk("alu_writereg", writereg, 7);
      chk("alu_writedata", writedata, 32'h1234);
      chk("alu_wbcount_pre", wbcount, 0);
      mem_memtoreg = 1; mem_readdata = 32'hDEAD_BEEF; mem_rd = 3;
      tick;
      chk("alu_wbcount", wbcount, 1);
      chk("rf7", rf[7], 32'h1234);
      chk("ld_writereg", writereg, 3);
      chk("ld_writedata", writedata, 32'hDEAD_BEEF);
      mem_rd = 0;
      tick;
      chk("r0_regwrite", regwrite, 0);
      chk("ld_wbcount", wbcount, 2);
      mem_regwrite = 0;
      tick;
      chk("r0_wbcount", wbcount, 2);
      chk("rf0", rf[0], 0);
      chk("rf3", rf[3], 32'hDEAD_BEEF);
      mem_regwrite = 1; mem_memtoreg = 0; mem_rd = 4; mem_aluresult = 32'h44;
      tick;
      ex_rs = 4; ex_rt = 4;
      #1;
      chk("fwd_mem_a", forwarda, 2'b10);
      chk("fwd_mem_b", forwardb, 2'b10);
      mem_regwrite = 0;
      #1;
      chk("fwd_wb_a", forwarda, 2'b01);
      chk("fwd_wb_b", forwardb, 2'b01);
      ex_rs = 0;
      #1;
      chk("fwd_zero_a", forwarda, 2'b00);
      chk("fwd_zero_b", forwardb, 2'b01);
      mem_regwrite = 1; mem_rd = 0; ex_rt = 0;
      #1;
      chk("fwd_memr0_b", forwardb, 2'b00);
      mem_rd = 9; mem_aluresult = 32'h55; ex_rt = 5;
      tick;
      chk("stl_wbcount0", wbcount, 3);
      chk("stl_writereg0", writereg, 9);
      stall = 1; mem_rd = 10; mem_aluresult = 32'h66;
      tick; tick; tick;
      chk("stl_writereg", writereg, 9);
      chk("stl_writedata", writedata, 32'h55);
      chk("stl_regwrite", regwrite, 1);
      chk("stl_wbcount", wbcount, 3);
      stall = 0;
      tick;
      chk("stl_wbcount_once", wbcount, 4);
      chk("stl_writereg_next", writereg, 10);
      flush = 1; stall = 1;
      tick;
      chk("fl_regwrite", regwrite, 0);
      chk("fl_writereg", writereg, 0);
      chk("fl_wbcount", wbcount, 4);
      flush = 0; stall = 0; mem_rd = 12; mem_aluresult = 32'h12;
      tick;
      chk("mr_regwrite_pre", regwrite, 1);
      reset = 0;
      tick;
      chk("mr_regwrite", regwrite, 0);
      chk("mr_wbcount", wbcount, 0);
      reset = 1; mem_regwrite = 0;
      tick;
      force dut.wbcount = 32'hFFFF_FFFF;
      #1;
      release dut.wbcount;
      #1;
      chk("wrap_preload", wbcount, 32'hFFFF_FFFF);
      mem_regwrite = 1; mem_rd = 1; mem_aluresult = 32'h1;
      tick;
      chk("wrap_hold", wbcount, 32'hFFFF_FFFF);
      mem_regwrite = 0;
      tick;
      chk("wrap_zero", wbcount, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
